// File: rtl/nsa_pkg.sv
// rtl/nsa_pkg.sv - shared state encoding and slice width for the nibble-serial adder
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder_cin.sv
// rtl/nibble_adder_cin.sv - combinational 4-bit adder slice with carry-in and carry-out
module nibble_adder_cin
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - wide adder built from one 4-bit slice, one nibble per clock, LSB first
module nibble_serial_add_ctrl
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_valid,
  output logic                          start_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout,
  output logic                          done_valid,
  input  logic                          done_ready,
  output logic                          busy
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NIBBLES - 1);

  state_t state, state_nxt;

  logic [W-1:0]        a_r, b_r, sum_r;
  logic                carry_r, cout_r;
  logic [CW-1:0]       idx;
  logic [CW+1:0]       shamt;
  logic [W-1:0]        a_sh, b_sh, nib_mask;
  logic [NIBBLE_W-1:0] s4;
  logic                c4;
  logic                last;
  logic                accept;

  // Bit offset of the current nibble is idx*4, formed by concatenation to stay width-exact.
  assign shamt    = {idx, 2'b00};
  assign a_sh     = a_r >> shamt;
  assign b_sh     = b_r >> shamt;
  assign nib_mask = W'({NIBBLE_W{1'b1}}) << shamt;
  assign last     = (idx == LAST_IDX);
  assign accept   = (state == IDLE) && start_valid;

  nibble_adder_cin u_slice (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry_r),
    .s    (s4),
    .cout (c4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    done_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done_valid = 1'b1;
        if (done_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Index parks at zero after the last nibble so it never wraps inside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b;
      carry_r <= cin;
      sum_r   <= '0;
      idx     <= '0;
    end else if (state == RUN) begin
      sum_r   <= (sum_r & ~nib_mask) | (W'(s4) << shamt);
      carry_r <= c4;
      idx     <= last ? '0 : idx + CW'(1);
      if (last) cout_r <= c4;
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - randomized self-checking bench with arithmetic reference model
module tb_nibble_serial_add_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         done_valid;
  logic         done_ready = 1'b0;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  nibble_serial_add_ctrl #(.NIBBLES(NIB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sum         (sum),
    .cout        (cout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_c,
                        input int hold, input bit poke, input string tag);
    logic [W:0] exp;
    int k;
    int lat;
    exp = ref_add(op_a, op_b, op_c);
    @(negedge clk);
    a = op_a; b = op_b; cin = op_c; start_valid = 1'b1;
    k = 0;
    while (!start_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s start_accept: start_ready=%b required 1", tag, start_ready);
      start_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!done_valid && lat < 50) begin
      checks++;
      if (busy !== 1'b1 || start_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s run_flags: busy=%b start_ready=%b required 1/0", tag, busy, start_ready);
      end
      if (poke) begin
        start_valid = 1'($urandom);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    start_valid = 1'b0;
    checks++;
    if (lat !== NIB) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", tag, lat, NIB);
    end
    checks++;
    if ({cout, sum} !== exp) begin
      errors++;
      $display("FAIL %s result: got cout=%b sum=%h required cout=%b sum=%h", tag, cout, sum, exp[W], exp[W-1:0]);
    end
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        start_valid = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      checks++;
      if (done_valid !== 1'b1 || start_ready !== 1'b0 || {cout, sum} !== exp) begin
        errors++;
        $display("FAIL %s hold%0d: done_valid=%b start_ready=%b cout=%b sum=%h required 1/0/%b/%h",
                 tag, i, done_valid, start_ready, cout, sum, exp[W], exp[W-1:0]);
      end
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    checks++;
    if (done_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0 || {cout, sum} !== exp) begin
      errors++;
      $display("FAIL %s release: done_valid=%b start_ready=%b busy=%b cout=%b sum=%h required 0/1/0/%b/%h",
               tag, done_valid, start_ready, busy, cout, sum, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (sum !== '0 || cout !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: sum=%h cout=%b done_valid=%b busy=%b start_ready=%b required 0/0/0/0/1",
               sum, cout, done_valid, busy, start_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, "dir_5555");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "dir_ripple");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, "dir_max");
    run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0, "dir_cin_only");
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0, "random");
  endtask

  task automatic test_backpressure();
    run_op(W'($urandom), W'($urandom), 1'($urandom), 5, 1'b1, "backpressure");
    run_op(16'h8000, 16'h8000, 1'b0, 5, 1'b1, "backpressure_cout");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b1; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sum !== '0 || cout !== 1'b0 || done_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: sum=%h cout=%b done_valid=%b busy=%b required 0/0/0/0", sum, cout, done_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (start_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_ready: start_ready=%b required 1", start_ready);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] oa[2];
    logic [W-1:0] ob[2];
    logic         oc[2];
    logic [W:0]   got[$];
    int           t_acc[2];
    int           n_acc;
    bit           pend;
    for (int i = 0; i < 2; i++) begin
      oa[i] = W'($urandom); ob[i] = W'($urandom); oc[i] = 1'($urandom);
    end
    n_acc = 0;
    pend = 1'b0;
    @(negedge clk);
    done_ready = 1'b1;
    a = oa[0]; b = ob[0]; cin = oc[0]; start_valid = 1'b1;
    for (int c = 0; c < 40 && got.size() < 2; c++) begin
      if (pend) begin
        pend = 1'b0;
        if (n_acc == 1) begin
          a = oa[1]; b = ob[1]; cin = oc[1];
        end else begin
          start_valid = 1'b0;
        end
      end
      if (start_valid && start_ready) begin
        t_acc[n_acc] = cyc;
        n_acc++;
        pend = 1'b1;
      end
      @(negedge clk);
      if (done_valid) got.push_back({cout, sum});
    end
    start_valid = 1'b0;
    done_ready = 1'b0;
    checks++;
    if (n_acc != 2 || got.size() != 2) begin
      errors++;
      $display("FAIL b2b_count: accepts=%0d results=%0d required 2/2", n_acc, got.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got[i] !== ref_add(oa[i], ob[i], oc[i])) begin
          errors++;
          $display("FAIL b2b_result%0d: got %h required %h", i, got[i], ref_add(oa[i], ob[i], oc[i]));
        end
      end
      checks++;
      if (t_acc[1] - t_acc[0] != NIB + 2) begin
        errors++;
        $display("FAIL b2b_interval: got %0d cycles required %0d", t_acc[1] - t_acc[0], NIB + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that performs a W-bit addition (W = 4*NIBBLES) by time-multiplexing a single 4-bit adder slice with carry-in, one nibble per clock, LSB nibble first.
- Sits between a requester (valid/ready start interface) and a consumer (valid/ready result interface).
- Serves as the area-minimal wide adder for the combinational-circuits track and as the first sequential controller built around the 4-bit adder datapath.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; legal range 1..16.
- W, 4*NIBBLES, operand/result width; derived and not overridable.
- CW, $clog2(NIBBLES) with a minimum of 1, width of the nibble index counter; derived.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  requester has operands on a/b/cin.
- start_ready  output  1  block can accept an operation.
- a  input  W  operand A; sampled only on start handshake.
- b  input  W  operand B; sampled only on start handshake.
- cin  input  1  carry-in to the LSB nibble; sampled only on start handshake.
- sum  output  W  result; registered.
- cout  output  1  carry-out of the MSB nibble; registered.
- done_valid  output  1  sum/cout hold a completed result.
- done_ready  input  1  consumer accepts the result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: the asynchronous assertion of rst_n forces the following at any time, including mid-operation:
  - state = IDLE
  - sum = 0, cout = 0
  - done_valid = 0, busy = 0
  - internal operand and carry registers = 0, index = 0
  - start_ready = 1 after reset, since it is decoded from IDLE.
  - No partial result survives a reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On a clock edge with start_valid = 1:
    - latch a, b and cin into the operand registers and the carry register;
    - clear sum to 0 and set index = 0;
    - go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - start_ready = 0, busy = 1.
  - Each cycle, the adder slice computes {c4, s4} = A[index] + B[index] + carry, where A[index] and B[index] are nibbles and carry is the carry register.
  - At the clock edge: sum nibble[index] <= s4, carry <= c4, index <= index + 1.
  - When index == NIBBLES-1 at the edge: cout <= c4 and go to DONE.
- DONE:
  - done_valid = 1, busy = 1, start_ready = 0.
  - sum and cout are held stable until the handshake.
  - On an edge with done_ready = 1: go to IDLE and drop done_valid.
  - sum and cout keep their value after this, until the next start clears sum.
- Latency:
  - Start handshake at edge E0.
  - done_valid is high after edge E(NIBBLES), i.e. NIBBLES cycles after acceptance.
  - Minimum issue interval is NIBBLES+2 cycles: no start is accepted in the DONE→IDLE cycle.
- Arithmetic: the result is exact W+1-bit unsigned {cout,sum} = a + b + cin, and never saturates.
- Wrap-around: index never exceeds NIBBLES-1; the counter is not allowed to wrap inside RUN.
- NIBBLES = 1: RUN lasts exactly one cycle; the CW minimum of 1 keeps the counter legal.
- Inputs a, b and cin are don't-care outside the start handshake cycle. Changing them during RUN has no effect.
- start_valid during RUN or DONE is ignored. The requester must hold its request until start_ready is 1.
- done_ready while done_valid = 0 is ignored.

Decomposition:
- Shared package nsa_pkg:
  - state enum {IDLE, RUN, DONE} with 2-bit encoding;
  - constant NIBBLE_W = 4.
- One sub-module, nibble_adder_cin: combinational 4-bit adder with carry-in and carry-out, instantiated once.
- The controller holds the FSM, the index counter, the carry register, the operand registers and the result register.

Test Plan:
- NIBBLES=4, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0; done_valid rises exactly 4 cycles after the start edge.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1; carry ripples through all 4 nibble steps.
- a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1. Also a=0, b=0, cin=1 → sum=0x0001, cout=0.
- Backpressure:
  - Stimulus: done_ready held low 5 cycles after done_valid; start_valid pulsed high with new operands, and a/b toggled randomly during RUN.
  - Response: sum/cout/done_valid stay stable; start_ready stays 0 and the pulse is ignored; the result equals the originally latched operands.
- Reset mid-operation: assert rst_n=0 asynchronously 2 cycles into RUN → sum=0, cout=0, done_valid=0, busy=0 immediately. After release, start_ready=1, and a new 0x00FF+0x0001 returns 0x0100.
- Back-to-back: two operations issued as soon as start_ready allows, with done_ready tied to 1 → both results correct; the second start is accepted NIBBLES+2 cycles after the first.
